// File: rtl/frame_sched.sv
// Vertical-blank update scheduler: hands out one-at-a-time update slots to
// game clients while the VGA controller is outside the visible area.
module frame_sched #(
  parameter int unsigned N_CLIENTS = 3,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           y,
  input  logic                 run,
  output logic [N_CLIENTS-1:0] upd_req,
  input  logic [N_CLIENTS-1:0] upd_ack,
  input  logic                 clear,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 overrun,
  output logic [N_CLIENTS-1:0] timeout_err
);

  localparam int unsigned IDX_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned WCNT_W = (TO_W > 10) ? TO_W : 10;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_CLIENTS - 1);
  localparam logic [WCNT_W-1:0]    WCNT_MAX = WCNT_W'(TIMEOUT);
  localparam logic [9:0]           V_ACT    = 10'(V_ACTIVE);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0 = N_CLIENTS'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [WCNT_W-1:0]   wcnt, wcnt_n;
  logic                vb_d;
  logic                vb, frame_start;
  logic [N_CLIENTS-1:0] cur_bit;
  logic [N_CLIENTS-1:0] to_set;
  logic                ovr_set;
  logic [N_CLIENTS-1:0] upd_req_n;
  logic                busy_n;
  logic [15:0]         frame_cnt_n;
  logic                overrun_n;
  logic [N_CLIENTS-1:0] timeout_err_n;

  assign vb          = (y >= V_ACT);
  assign frame_start = vb & ~vb_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, sequencing and sticky flag logic
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wcnt_n      = wcnt;
    frame_cnt_n = frame_cnt;
    ovr_set     = 1'b0;
    to_set      = '0;
    cur_bit     = ONE_HOT0 << idx;

    case (state)
      ST_IDLE: begin
        if (frame_start && run) begin
          state_n     = ST_WAIT;
          idx_n       = '0;
          wcnt_n      = '0;
          frame_cnt_n = frame_cnt + 16'd1;
        end
      end
      ST_WAIT: begin
        // Active video returning beats any ack or timeout on the same edge
        if (!vb) begin
          ovr_set = 1'b1;
          state_n = ST_IDLE;
          idx_n   = '0;
          wcnt_n  = '0;
        end else if (upd_ack[idx] || (wcnt == WCNT_MAX)) begin
          if (!upd_ack[idx]) begin
            to_set = cur_bit;
          end
          wcnt_n = '0;
          if (idx == LAST_IDX) begin
            state_n = ST_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          wcnt_n = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        wcnt_n  = '0;
      end
    endcase

    upd_req_n     = (state_n == ST_WAIT) ? (ONE_HOT0 << idx_n) : '0;
    busy_n        = (state_n == ST_WAIT);
    overrun_n     = (overrun & ~clear) | ovr_set;
    timeout_err_n = (timeout_err & ~{N_CLIENTS{clear}}) | to_set;
  end

  // Datapath and output registers; vb_d resets high so a release in blank is quiet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      wcnt        <= '0;
      vb_d        <= 1'b1;
      upd_req     <= '0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      idx         <= idx_n;
      wcnt        <= wcnt_n;
      vb_d        <= vb;
      upd_req     <= upd_req_n;
      busy        <= busy_n;
      frame_cnt   <= frame_cnt_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: vector table, directed corner cases,
// and randomized traffic against a frame/client-level reference model.
module tb_frame_sched;

  localparam int NC      = 3;
  localparam int VACT    = 480;
  localparam int TMO     = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    y;
  logic          run;
  logic [NC-1:0] upd_req;
  logic [NC-1:0] upd_ack;
  logic          clear;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic [NC-1:0] timeout_err;

  int checks = 0;
  int errors = 0;

  frame_sched #(.N_CLIENTS(NC), .V_ACTIVE(VACT), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .y           (y),
    .run         (run),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .clear       (clear),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached (act running, req finished)");
    $fatal(1, "watchdog");
  end

  // Reference model: which client currently holds the slot, how long it has held it
  int          m_client;   // -1 when no sequence is in progress
  int          m_held;
  bit          m_prev_blank;
  logic [15:0] m_frames;
  logic        m_ovr;
  logic [2:0]  m_to;

  task automatic model_reset();
    m_client     = -1;
    m_held       = 0;
    m_prev_blank = 1'b1;
    m_frames     = 16'd0;
    m_ovr        = 1'b0;
    m_to         = 3'b000;
  endtask

  task automatic model_step();
    bit         blank;
    bit         ovr_ev;
    logic [2:0] to_ev;
    blank  = (int'(y) >= VACT);
    ovr_ev = 1'b0;
    to_ev  = 3'b000;
    if (m_client < 0) begin
      if (blank && !m_prev_blank && run) begin
        m_client = 0;
        m_held   = 0;
        m_frames = m_frames + 16'd1;
      end
    end else if (!blank) begin
      ovr_ev   = 1'b1;
      m_client = -1;
    end else if (upd_ack[m_client] || m_held == TMO) begin
      if (!upd_ack[m_client]) to_ev[m_client] = 1'b1;
      m_client = (m_client == NC - 1) ? -1 : m_client + 1;
      m_held   = 0;
    end else begin
      m_held++;
    end
    m_ovr        = (m_ovr && !clear) || ovr_ev;
    m_to         = (clear ? 3'b000 : m_to) | to_ev;
    m_prev_blank = blank;
  endtask

  function automatic logic [23:0] model_vec();
    logic [2:0] r;
    r = (m_client < 0) ? 3'b000 : 3'(1 << m_client);
    return {r, (m_client >= 0), m_frames, m_ovr, m_to};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  y;
    logic        run;
    logic [2:0]  ack;
    logic        clr;
    logic [2:0]  req;
    logic        bsy;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int n;
    int pct;
    int flip_div;
    bit in_blank;

    vecs[0]  = '{10'd479, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 16'd0};
    vecs[1]  = '{10'd480, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 16'd1};
    vecs[2]  = '{10'd480, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 16'd1};
    vecs[3]  = '{10'd480, 1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 16'd1};
    vecs[4]  = '{10'd480, 1'b1, 3'b101, 1'b0, 3'b010, 1'b1, 16'd1};
    vecs[5]  = '{10'd480, 1'b1, 3'b010, 1'b0, 3'b100, 1'b1, 16'd1};
    vecs[6]  = '{10'd480, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 16'd1};
    vecs[7]  = '{10'd480, 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[8]  = '{10'd480, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[9]  = '{10'd479, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[10] = '{10'd480, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[11] = '{10'd481, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[12] = '{10'd0,   1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1};
    vecs[13] = '{10'd480, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 16'd2};
    vecs[14] = '{10'd480, 1'b0, 3'b001, 1'b0, 3'b010, 1'b1, 16'd2};
    vecs[15] = '{10'd480, 1'b0, 3'b010, 1'b0, 3'b100, 1'b1, 16'd2};
    vecs[16] = '{10'd480, 1'b0, 3'b100, 1'b0, 3'b000, 1'b0, 16'd2};

    reset   = 1'b0;
    y       = 10'd479;
    run     = 1'b1;
    upd_ack = '0;
    clear   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(upd_req),     32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_fc",    32'(frame_cnt),   32'd0);
    chk("rst_ovr",   32'(overrun),     32'd0);
    chk("rst_to",    32'(timeout_err), 32'd0);
    reset = 1'b1;

    // Basic sequence, wrong-bit acks, run=0 frames, run falling mid-sequence
    for (int i = 0; i < 17; i++) begin
      y = vecs[i].y; run = vecs[i].run; upd_ack = vecs[i].ack; clear = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i), 32'({upd_req, busy, frame_cnt}),
          32'({vecs[i].req, vecs[i].bsy, vecs[i].fc}));
    end
    upd_ack = '0; run = 1'b1;
    chk("vec_flags", 32'({overrun, timeout_err}), 32'd0);

    // Client 1 never acks: held for TIMEOUT+1 cycles, then client 2
    y = 10'd479; tick();
    y = 10'd480; tick();
    chk("to_req0", 32'(upd_req), 32'b001);
    upd_ack = 3'b001; tick();
    upd_ack = 3'b000;
    chk("to_req1", 32'(upd_req), 32'b010);
    n = 0;
    while (upd_req == 3'b010 && n < 1100) begin
      tick();
      n++;
    end
    chk("to_hold_cycles", 32'(n), 32'd1024);
    chk("to_err",  32'(timeout_err), 32'b010);
    chk("to_next", 32'({upd_req, busy}), 32'({3'b100, 1'b1}));

    // Active video returns while waiting on client 2
    repeat (3) tick();
    y = 10'd0; tick();
    chk("ovr_req",  32'({upd_req, busy}), 32'd0);
    chk("ovr_flag", 32'({overrun, timeout_err}), 32'({1'b1, 3'b010}));
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_flags", 32'({overrun, timeout_err}), 32'd0);

    // Overrun on the same edge as clear: set wins
    y = 10'd479; tick();
    y = 10'd480; tick();
    y = 10'd0; clear = 1'b1; tick();
    clear = 1'b0;
    chk("ovr_beats_clr", 32'(overrun), 32'd1);
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_again", 32'(overrun), 32'd0);

    // Asynchronous reset mid-sequence
    y = 10'd479; tick();
    y = 10'd480; tick();
    upd_ack = 3'b001; tick();
    upd_ack = 3'b000;
    chk("ar_pre", 32'(upd_req), 32'b010);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_req", 32'(upd_req), 32'd0);
    chk("ar_all", 32'({busy, frame_cnt, overrun, timeout_err}), 32'd0);
    model_reset();

    // Release reset inside vertical blank: no spurious frame start
    y = 10'd500;
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    repeat (5) tick();
    chk("rel_quiet", 32'({upd_req, busy, frame_cnt}), 32'd0);
    y = 10'd479; tick();
    y = 10'd480; tick();
    chk("rel_start", 32'({upd_req, busy, frame_cnt}), 32'({3'b001, 1'b1, 16'd1}));
    for (int c = 0; c < NC; c++) begin
      upd_ack = 3'(1 << c);
      tick();
    end
    upd_ack = '0;
    chk("rel_done", 32'({upd_req, busy}), 32'd0);

    // Randomized traffic against the reference model
    in_blank = 1'b1;
    for (int p = 0; p < 16 && errors < 20; p++) begin
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 20;
        2:       pct = 50;
        default: pct = 90;
      endcase
      flip_div = ($urandom_range(0, 2) == 0) ? 1500 : 25;
      for (int k = 0; k < 2500 && errors < 20; k++) begin
        if ($urandom_range(0, flip_div - 1) == 0) in_blank = !in_blank;
        y       = in_blank ? 10'($urandom_range(480, 524)) : 10'($urandom_range(0, 479));
        run     = ($urandom_range(0, 9) != 0);
        clear   = ($urandom_range(0, 99) < 3);
        for (int b = 0; b < NC; b++) upd_ack[b] = ($urandom_range(0, 99) < pct);
        tick();
        chk("rand", 32'({upd_req, busy, frame_cnt, overrun, timeout_err}), 32'(model_vec()));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter N_CLIENTS, default 3, SHALL set the number of update requesters (1..8).
REQ-002 Parameter V_ACTIVE, default 480, SHALL set the first non-visible line number.
REQ-003 Parameter TIMEOUT, default 1023, SHALL set the maximum wait cycles per client acknowledge.
REQ-004 clk  in  1  SHALL be the single pixel clock; all state updates on rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset (asserted when 0).
REQ-006 y  in  10  SHALL be the current line number from the VGA controller.
REQ-007 run  in  1  SHALL enable game update sequencing when high.
REQ-008 upd_req  out  N_CLIENTS  SHALL be the per-client update request, at most one bit high.
REQ-009 upd_ack  in  N_CLIENTS  SHALL be the per-client update acknowledge.
REQ-010 clear  in  1  SHALL clear the sticky error flags when high.
REQ-011 busy  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-012 frame_cnt  out  16  SHALL count started update frames.
REQ-013 overrun  out  1  SHALL be a sticky flag: sequence aborted by active video resuming.
REQ-014 timeout_err  out  N_CLIENTS  SHALL be sticky per-client acknowledge-timeout flags.

Function
REQ-015 vb = (y >= V_ACTIVE), registered each cycle into vb_d; frame_start = vb & ~vb_d.
REQ-016 FSM states SHALL be IDLE and WAIT; index register idx (0..N_CLIENTS-1); wait counter wcnt, 10 bits minimum.
REQ-017 IDLE: on frame_start with run=1 -> WAIT, idx=0, wcnt=0, upd_req[0]=1 at that same edge (upd_req high one clock after y first presented >= V_ACTIVE).
REQ-018 frame_start with run=0 SHALL be ignored: no request issued, frame_cnt unchanged.
REQ-019 frame_cnt SHALL increment by 1 on each accepted frame_start, wrapping 16'hFFFF -> 0.
REQ-020 WAIT: upd_req[idx] SHALL hold high until an edge sampling upd_ack[idx]=1.
REQ-021 On ack with idx < N_CLIENTS-1: upd_req[idx]->0 and upd_req[idx+1]->1 at the same edge, wcnt=0 (back-to-back, no gap cycle).
REQ-022 On ack with idx = N_CLIENTS-1: upd_req->0, FSM -> IDLE.
REQ-023 Acks on bits other than the currently requested bit SHALL be ignored.
REQ-024 wcnt SHALL increment every WAIT cycle without ack; when wcnt = TIMEOUT, that edge sets timeout_err[idx] and advances as if acked (REQ-021/022).
REQ-025 If vb=0 (active video) is sampled while in WAIT, at that edge: upd_req->0, overrun->1, FSM -> IDLE; overrun takes precedence over a simultaneous ack or timeout.
REQ-026 run falling mid-sequence SHALL NOT abort; the sequence completes normally.
REQ-027 clear=1 SHALL zero overrun and timeout_err; a set event at the same edge wins over clear.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 While reset=0: FSM=IDLE, upd_req=0, busy=0, frame_cnt=0, overrun=0, timeout_err=0, idx=0, wcnt=0.
REQ-030 vb_d SHALL reset to 1 so releasing reset during vertical blank produces no spurious frame_start.
REQ-031 Reset asserted mid-sequence SHALL drop upd_req immediately (asynchronously), with no flag set.

Verification
REQ-032 run=1, y steps 479->480, each client acks 2 cycles after its req -> upd_req sequence 001,010,100 back-to-back, frame_cnt 0->1, busy low after last ack.
REQ-033 Client 1 never acks, TIMEOUT=1023 -> upd_req[1] high exactly 1024 cycles, timeout_err=3'b010, client 2 then requested.
REQ-034 y returns to 0 while waiting on client 2 -> upd_req=0 next edge, overrun=1, busy=0; clear=1 one cycle -> overrun=0.
REQ-035 run=0 across a 479->480 transition -> upd_req stays 0, frame_cnt unchanged.
REQ-036 Reset released with y=500 -> no request until the next 479->480 transition; frame_cnt preloaded via 65535 frames wraps to 0.
REQ-037 reset pulsed low while upd_req=3'b010 -> upd_req=0 without waiting for a clock edge, all flags 0.
